// File: rtl/hazard_ctrl_p_if.sv
// ============================================================================
//  Module   : hazard_ctrl_p_if
//  Brief    : ID/EX hazard-control signal bundle between the pipeline and the
//             hazard controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_p_if #(
    parameter int RA_W = 5
);
    logic            jump;
    logic            branch;
    logic            branch_ne;
    logic            alu_zero;
    logic            mem_read_ex;
    logic [RA_W-1:0] curr_rs;
    logic [RA_W-1:0] curr_rt;
    logic [RA_W-1:0] prev_rt;
    logic            use_shamt;
    logic            use_immed;
    logic            mdu_start;
    logic            mdu_use;

    logic            pc_write;
    logic            if_write;
    logic            bubble;
    logic [1:0]      addr_sel;
    logic            mdu_busy;

    modport master (
        output jump, branch, branch_ne, alu_zero, mem_read_ex,
        output curr_rs, curr_rt, prev_rt, use_shamt, use_immed,
        output mdu_start, mdu_use,
        input  pc_write, if_write, bubble, addr_sel, mdu_busy
    );

    modport slave (
        input  jump, branch, branch_ne, alu_zero, mem_read_ex,
        input  curr_rs, curr_rt, prev_rt, use_shamt, use_immed,
        input  mdu_start, mdu_use,
        output pc_write, if_write, bubble, addr_sel, mdu_busy
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_p.sv
// ============================================================================
//  Module   : hazard_ctrl_p
//  Brief    : 5-stage MIPS hazard controller: jump, load-use, MDU and branch
//             interlocks driving PC/IF enables, bubble insert and PC select.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_p #(
    parameter int RA_W      = 5,
    parameter int LD_STALL  = 1,
    parameter int MDU_LAT   = 4,
    parameter int ZERO_FILT = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    hazard_ctrl_p_if.slave  hz
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_JUMP     = 3'd1,
        S_LDSTALL  = 3'd2,
        S_BR_EVAL  = 3'd3,
        S_BR_TAKEN = 3'd4
    } state_t;

    localparam logic [1:0] C_SEL_PC4  = 2'b00;
    localparam logic [1:0] C_SEL_JUMP = 2'b01;
    localparam logic [1:0] C_SEL_BR   = 2'b10;
    localparam logic [1:0] C_LD_INIT  = 2'(LD_STALL - 1);
    localparam logic [3:0] C_MDU_LAT  = 4'(MDU_LAT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ld_cnt;
    logic [1:0] w_ld_cnt_nxt;
    logic [3:0] r_mdu_cnt;
    logic [3:0] w_mdu_cnt_nxt;
    logic       r_br_ne;
    logic       w_br_ne_nxt;

    logic       w_rs_hit;
    logic       w_rt_hit;
    logic       w_zero_masked;
    logic       w_ld_haz;
    logic       w_mdu_busy;
    logic       w_mdu_haz;

    logic       w_pc_write;
    logic       w_if_write;
    logic       w_bubble;
    logic [1:0] w_addr_sel;

    assign w_rs_hit      = !hz.use_shamt && (hz.curr_rs == hz.prev_rt);
    assign w_rt_hit      = !hz.use_immed && (hz.curr_rt == hz.prev_rt);
    assign w_zero_masked = (ZERO_FILT != 0) && (hz.prev_rt == '0);
    assign w_ld_haz      = hz.mem_read_ex && !w_zero_masked && (w_rs_hit || w_rt_hit);

    assign w_mdu_busy    = (r_mdu_cnt != 4'd0);
    assign w_mdu_haz     = w_mdu_busy && hz.mdu_use;

    // MDU counter runs independently of the FSM; a new start always reloads.
    always_comb begin
        if (hz.mdu_start) begin
            w_mdu_cnt_nxt = C_MDU_LAT;
        end else if (r_mdu_cnt != 4'd0) begin
            w_mdu_cnt_nxt = r_mdu_cnt - 4'd1;
        end else begin
            w_mdu_cnt_nxt = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ld_cnt  <= 2'd0;
            r_mdu_cnt <= 4'd0;
            r_br_ne   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_cnt  <= w_ld_cnt_nxt;
            r_mdu_cnt <= w_mdu_cnt_nxt;
            r_br_ne   <= w_br_ne_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_cnt_nxt = r_ld_cnt;
        w_br_ne_nxt  = r_br_ne;
        w_pc_write   = 1'b1;
        w_if_write   = 1'b1;
        w_bubble     = 1'b0;
        w_addr_sel   = C_SEL_PC4;

        case (r_state)
            S_IDLE: begin
                if (hz.jump) begin
                    w_if_write  = 1'b0;
                    w_bubble    = 1'b1;
                    w_addr_sel  = C_SEL_JUMP;
                    w_state_nxt = S_JUMP;
                end else if (w_ld_haz) begin
                    w_pc_write   = 1'b0;
                    w_if_write   = 1'b0;
                    w_bubble     = 1'b1;
                    w_ld_cnt_nxt = C_LD_INIT;
                    w_state_nxt  = S_LDSTALL;
                end else if (w_mdu_haz) begin
                    w_pc_write = 1'b0;
                    w_if_write = 1'b0;
                    w_bubble   = 1'b1;
                end else if (hz.branch) begin
                    w_br_ne_nxt = hz.branch_ne;
                    w_state_nxt = S_BR_EVAL;
                end
            end
            S_JUMP: begin
                w_state_nxt = S_IDLE;
            end
            S_LDSTALL: begin
                if (r_ld_cnt != 2'd0) begin
                    w_pc_write   = 1'b0;
                    w_if_write   = 1'b0;
                    w_bubble     = 1'b1;
                    w_ld_cnt_nxt = r_ld_cnt - 2'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BR_EVAL: begin
                if (hz.alu_zero ^ r_br_ne) begin
                    w_if_write  = 1'b0;
                    w_bubble    = 1'b1;
                    w_addr_sel  = C_SEL_BR;
                    w_state_nxt = S_BR_TAKEN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BR_TAKEN: begin
                // Squash the wrong-path instruction already fetched.
                w_bubble    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (!rst_n) begin
            w_pc_write = 1'b0;
            w_if_write = 1'b0;
            w_bubble   = 1'b1;
            w_addr_sel = C_SEL_PC4;
        end
    end

    assign hz.pc_write = w_pc_write;
    assign hz.if_write = w_if_write;
    assign hz.bubble   = w_bubble;
    assign hz.addr_sel = w_addr_sel;
    assign hz.mdu_busy = rst_n && w_mdu_busy;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_p.sv
// ============================================================================
//  Module   : tb_hazard_ctrl_p
//  Brief    : Two differently-parameterised controllers on one stimulus stream,
//             compared cycle by cycle against a schedule-based model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_p;

    localparam int RA_W = 5;

    localparam logic [4:0] C_NORMAL = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00100;
    localparam logic [4:0] C_JUMP   = 5'b10101;
    localparam logic [4:0] C_BRT    = 5'b10110;
    localparam logic [4:0] C_FLUSH  = 5'b11100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            jump, branch, branch_ne, alu_zero, mem_read_ex;
    logic [RA_W-1:0] curr_rs, curr_rt, prev_rt;
    logic            use_shamt, use_immed, mdu_start, mdu_use;

    hazard_ctrl_p_if #(.RA_W(RA_W)) bus_a ();
    hazard_ctrl_p_if #(.RA_W(RA_W)) bus_b ();

    assign bus_a.jump = jump;               assign bus_b.jump = jump;
    assign bus_a.branch = branch;           assign bus_b.branch = branch;
    assign bus_a.branch_ne = branch_ne;     assign bus_b.branch_ne = branch_ne;
    assign bus_a.alu_zero = alu_zero;       assign bus_b.alu_zero = alu_zero;
    assign bus_a.mem_read_ex = mem_read_ex; assign bus_b.mem_read_ex = mem_read_ex;
    assign bus_a.curr_rs = curr_rs;         assign bus_b.curr_rs = curr_rs;
    assign bus_a.curr_rt = curr_rt;         assign bus_b.curr_rt = curr_rt;
    assign bus_a.prev_rt = prev_rt;         assign bus_b.prev_rt = prev_rt;
    assign bus_a.use_shamt = use_shamt;     assign bus_b.use_shamt = use_shamt;
    assign bus_a.use_immed = use_immed;     assign bus_b.use_immed = use_immed;
    assign bus_a.mdu_start = mdu_start;     assign bus_b.mdu_start = mdu_start;
    assign bus_a.mdu_use = mdu_use;         assign bus_b.mdu_use = mdu_use;

    hazard_ctrl_p #(.RA_W(RA_W), .LD_STALL(2), .MDU_LAT(4), .ZERO_FILT(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_a)
    );

    hazard_ctrl_p #(.RA_W(RA_W), .LD_STALL(4), .MDU_LAT(2), .ZERO_FILT(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_b)
    );

    wire [5:0] out_a = {bus_a.pc_write, bus_a.if_write, bus_a.bubble, bus_a.addr_sel, bus_a.mdu_busy};
    wire [5:0] out_b = {bus_b.pc_write, bus_b.if_write, bus_b.bubble, bus_b.addr_sel, bus_b.mdu_busy};

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] obs [2];

    // Model: committed outputs for upcoming cycles, a pending branch decision
    // and the remaining MDU busy time.
    logic [4:0] sched [2][8];
    int         sched_n [2];
    bit         br_eval [2];
    bit         br_ne_m [2];
    int         mdu_left [2];

    function automatic int ld_stall_of(int k);
        return (k == 0) ? 2 : 4;
    endfunction
    function automatic int mdu_lat_of(int k);
        return (k == 0) ? 4 : 2;
    endfunction
    function automatic bit zfilt_of(int k);
        return (k == 0);
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit ld_haz(int k);
        if (!mem_read_ex) return 1'b0;
        if (zfilt_of(k) && prev_rt == 0) return 1'b0;
        return (!use_shamt && curr_rs == prev_rt) || (!use_immed && curr_rt == prev_rt);
    endfunction

    function automatic logic [5:0] exp_out(int k);
        logic [4:0] v;
        bit busy;
        if (!rst_n) return 6'b001000;
        busy = (mdu_left[k] != 0);
        if (sched_n[k] > 0)            v = sched[k][0];
        else if (br_eval[k])           v = (alu_zero ^ br_ne_m[k]) ? C_BRT : C_NORMAL;
        else if (jump)                 v = C_JUMP;
        else if (ld_haz(k))            v = C_STALL;
        else if (busy && mdu_use)      v = C_STALL;
        else                           v = C_NORMAL;
        return {v, busy};
    endfunction

    task automatic push(input int k, input logic [4:0] v);
        sched[k][sched_n[k]] = v;
        sched_n[k]++;
    endtask

    task automatic model_update(input int k);
        int nxt_mdu;
        bit busy;
        if (!rst_n) begin
            sched_n[k] = 0; br_eval[k] = 0; mdu_left[k] = 0;
            return;
        end
        busy    = (mdu_left[k] != 0);
        nxt_mdu = mdu_start ? mdu_lat_of(k) : (busy ? mdu_left[k] - 1 : 0);
        if (sched_n[k] > 0) begin
            for (int i = 0; i < 7; i++) sched[k][i] = sched[k][i+1];
            sched_n[k]--;
        end else if (br_eval[k]) begin
            br_eval[k] = 0;
            if (alu_zero ^ br_ne_m[k]) push(k, C_FLUSH);
        end else if (jump) begin
            push(k, C_NORMAL);
        end else if (ld_haz(k)) begin
            for (int i = 0; i < ld_stall_of(k) - 1; i++) push(k, C_STALL);
            push(k, C_NORMAL);
        end else if (!(busy && mdu_use) && branch) begin
            br_eval[k] = 1;
            br_ne_m[k] = branch_ne;
        end
        mdu_left[k] = nxt_mdu;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic cycle();
        @(negedge clk);
        obs[0] = out_a;
        obs[1] = out_b;
        check_val("out_a", {2'b00, obs[0]}, {2'b00, exp_out(0)});
        check_val("out_b", {2'b00, obs[1]}, {2'b00, exp_out(1)});
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic clear_inputs();
        jump = 0; branch = 0; branch_ne = 0; alu_zero = 0; mem_read_ex = 0;
        curr_rs = 0; curr_rt = 0; prev_rt = 0; use_shamt = 0; use_immed = 0;
        mdu_start = 0; mdu_use = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int st_a, st_b;
        for (int k = 0; k < 2; k++) begin
            sched_n[k] = 0; br_eval[k] = 0; br_ne_m[k] = 0; mdu_left[k] = 0;
            for (int i = 0; i < 8; i++) sched[k][i] = '0;
        end
        clear_inputs();
        rst_n = 0;
        @(posedge clk); #1;

        // Reset held two cycles, then release.
        cycle();
        cycle();
        check_val("rst_a", {2'b00, obs[0]}, 8'b00001000);
        check_val("rst_b", {2'b00, obs[1]}, 8'b00001000);
        rst_n = 1;
        cycle();
        check_val("rel_a", {2'b00, obs[0]}, 8'b00110000);

        // Load-use on rs: 2 stalls (A), 4 stalls (B).
        mem_read_ex = 1; prev_rt = 8; curr_rs = 8; curr_rt = 1; use_immed = 1;
        st_a = 0; st_b = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (obs[0][3] && !obs[0][5]) st_a++;
            if (obs[1][3] && !obs[1][5]) st_b++;
            mem_read_ex = 0;
        end
        check_val("ld_stall_a", 8'(st_a), 8'd2);
        check_val("ld_stall_b", 8'(st_b), 8'd4);

        // Register 0: filtered on A, a real hazard on B.
        mem_read_ex = 1; prev_rt = 0; curr_rs = 0;
        st_a = 0; st_b = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (obs[0][3] && !obs[0][5]) st_a++;
            if (obs[1][3] && !obs[1][5]) st_b++;
            mem_read_ex = 0;
        end
        check_val("zero_a", 8'(st_a), 8'd0);
        check_val("zero_b", 8'(st_b), 8'd4);

        // Jump and load-use together: jump wins.
        clear_inputs();
        jump = 1; mem_read_ex = 1; prev_rt = 5; curr_rs = 5;
        cycle();
        check_val("jmp_a", {2'b00, obs[0]}, 8'b00101010);
        clear_inputs();
        cycle();
        check_val("jmp_after", {2'b00, obs[0]}, 8'b00110000);

        // beq taken, then flush.
        branch = 1; branch_ne = 0;
        cycle();
        branch = 0; alu_zero = 1;
        cycle();
        check_val("beq_tk", {2'b00, obs[0]}, 8'b00101100);
        alu_zero = 0;
        cycle();
        check_val("beq_fl", {2'b00, obs[0]}, 8'b00111000);

        // bne with equal operands: not taken.
        branch = 1; branch_ne = 1;
        cycle();
        branch = 0; alu_zero = 1;
        cycle();
        check_val("bne_nt", {2'b00, obs[0]}, 8'b00110000);
        clear_inputs();

        // MDU interlock, held use until released.
        mdu_start = 1;
        cycle();
        mdu_start = 0; mdu_use = 1;
        for (int i = 0; i < 7; i++) cycle();
        check_val("mdu_rel_a", {2'b00, obs[0]}, 8'b00110000);
        clear_inputs();

        // Reset in the middle of a long load stall on B.
        mem_read_ex = 1; prev_rt = 3; curr_rt = 3; use_shamt = 1;
        cycle();
        clear_inputs();
        cycle();
        rst_n = 0;
        cycle();
        rst_n = 1;
        cycle();
        check_val("ld_abort_b", {2'b00, obs[1]}, 8'b00110000);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 99) >= 2);
            jump        = ($urandom_range(0, 9) == 0);
            branch      = ($urandom_range(0, 4) == 0);
            branch_ne   = 1'($urandom);
            alu_zero    = 1'($urandom);
            mem_read_ex = ($urandom_range(0, 2) == 0);
            curr_rs     = RA_W'($urandom_range(0, 3));
            curr_rt     = RA_W'($urandom_range(0, 3));
            prev_rt     = RA_W'($urandom_range(0, 3));
            use_shamt   = ($urandom_range(0, 3) == 0);
            use_immed   = ($urandom_range(0, 2) == 0);
            mdu_start   = ($urandom_range(0, 11) == 0);
            mdu_use     = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
